ef_apb_master_bridge: RTL and testbench
=======================================

// Module: ef_apb_master_bridge
// PURPOSE
//  APB initiator: turns a valid/ready request stream (write/read, addr, data) into
//  APB3 transfers and returns a response stream. Lets on-chip agents (debug
//  bridge, DMA, sequencers) drive APB responders such as the UART's APB wrapper.
//  One transfer outstanding at a time; sits between the agent and the APB bus/decoder.
// PARAMETERS
//  AW       32   PADDR / req_addr width
//  DW       32   PWDATA / PRDATA / req_wdata / rsp_rdata width
//  TIMEOUT  256  max ACCESS cycles waiting for PREADY (used only with EF_APBM_TIMEOUT_EN)
// PORTS
//  PCLK       in   1   clock; all logic on rising edge
//  PRESET     in   1   synchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   request accepted when req_valid & req_ready
//  req_write  in   1   1=write, 0=read
//  req_addr   in   AW  target address
//  req_wdata  in   DW  write data (ignored for reads)
//  rsp_valid  out  1   response present
//  rsp_ready  in   1   response consumed when rsp_valid & rsp_ready
//  rsp_rdata  out  DW  read data; 0 for writes and errors
//  rsp_err    out  1   PSLVERR seen, or timeout
//  PSEL       out  1   APB select
//  PENABLE    out  1   APB enable
//  PWRITE     out  1   APB direction
//  PADDR      out  AW  APB address
//  PWDATA     out  DW  APB write data
//  PREADY     in   1   responder ready
//  PRDATA     in   DW  responder read data
//  PSLVERR    in   1   responder error
// BEHAVIOUR
//  - Reset: state IDLE; req_ready=1; all other outputs 0. Reset mid-transfer drops
//    it immediately (PSEL/PENABLE low after the reset edge); no response issued.
//  - FSM: IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//    IDLE: req_ready=1; on handshake register write/addr/wdata, go SETUP.
//    SETUP (1 cycle): PSEL=1, PENABLE=0, PADDR/PWRITE/PWDATA valid; go ACCESS.
//    ACCESS: PSEL=1, PENABLE=1, bus signals held stable; stay while PREADY=0.
//      PREADY=1: rsp_rdata <= PWRITE?0:PRDATA, rsp_err <= PSLVERR; PSEL, PENABLE
//      drop next cycle; go RESP.
//    RESP: rsp_valid=1, rsp_rdata/rsp_err held until rsp_ready; then IDLE.
//  - req_ready=0 in every state except IDLE; requests are never buffered.
//  - Latency, zero-wait responder, rsp_ready=1: handshake at edge n, PSEL at n+1,
//    PENABLE at n+2, rsp_valid at n+3, req_ready at n+4 -> 4 cycles per transfer.
//  - PADDR/PWDATA/PWRITE hold their last values outside transfers (not cleared).
//  - On PSLVERR=1 with a read, rsp_rdata=0 and rsp_err=1.
// CONFIGURATION
//  EF_APBM_TIMEOUT_EN defined: cycle counter (clog2(TIMEOUT+1) bits) cleared on
//    ACCESS entry, incremented each ACCESS cycle with PREADY=0. When it reaches
//    TIMEOUT: abort; PSEL/PENABLE drop; RESP with rsp_err=1, rsp_rdata=0. PREADY
//    on the same cycle as expiry wins: normal completion.
//  Not defined: no counter; ACCESS waits indefinitely for PREADY; TIMEOUT unused.
// TESTING
//  1 Zero-wait slave: write 0xA5 to 0x10, read 0x10 -> rsp_rdata=0xA5,
//    rsp_err=0, exactly 4 cycles from req handshake to next req_ready.
//  2 Slave inserts 3 wait states -> PENABLE high 4 cycles, PADDR/PWDATA stable
//    throughout, rsp_valid 1 cycle after PREADY.
//  3 Read with PSLVERR=1, PRDATA=0x1234 -> rsp_err=1, rsp_rdata=0.
//  4 rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0,
//    PSEL=0; second queued request starts only after response handshake.
//  5 PRESET asserted during ACCESS -> next edge PSEL=PENABLE=rsp_valid=0,
//    req_ready=1; no response emitted.
//  6 (EF_APBM_TIMEOUT_EN, TIMEOUT=8) PREADY tied 0 -> abort after 8 ACCESS
//    cycles, rsp_err=1; repeat with PREADY on cycle 8 -> normal completion.

Source files
------------

// File: rtl/ef_apb_master_bridge.sv
// APB3 initiator: valid/ready request stream in, one APB transfer at a time, response stream out.
// Optional ACCESS-phase timeout enabled by defining EF_APBM_TIMEOUT_EN.
module ef_apb_master_bridge #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic          PWRITE,
  output logic [AW-1:0] PADDR,
  output logic [DW-1:0] PWDATA,
  input  logic          PREADY,
  input  logic [DW-1:0] PRDATA,
  input  logic          PSLVERR
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_RESP} state_t;

  state_t        r_state, w_next;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic          w_done;
  logic          w_abort;

  assign w_done = (r_state == S_ACCESS) && PREADY;

`ifdef EF_APBM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] r_cnt;

  // Counts wait cycles already spent in ACCESS; the cycle that would bring it to TIMEOUT aborts.
  always_ff @(posedge PCLK) begin
    if (PRESET)                               r_cnt <= '0;
    else if (r_state == S_SETUP)              r_cnt <= '0;
    else if (r_state == S_ACCESS && !PREADY)  r_cnt <= r_cnt + 1'b1;
  end

  assign w_abort = (r_state == S_ACCESS) && !PREADY && (r_cnt == CW'(TIMEOUT - 1));
`else
  assign w_abort = 1'b0 && (TIMEOUT != 0);
`endif

  always_ff @(posedge PCLK) begin
    if (PRESET) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (req_valid)          w_next = S_SETUP;
      S_SETUP:                          w_next = S_ACCESS;
      S_ACCESS: if (w_done || w_abort)  w_next = S_RESP;
      S_RESP:   if (rsp_ready)          w_next = S_IDLE;
      default:                          w_next = S_IDLE;
    endcase
  end

  // Bus fields hold their last value between transfers; only reset clears them.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_pwrite <= 1'b0;
      r_paddr  <= '0;
      r_pwdata <= '0;
      r_rdata  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state == S_IDLE && req_valid) begin
        r_pwrite <= req_write;
        r_paddr  <= req_addr;
        r_pwdata <= req_wdata;
      end
      if (w_done) begin
        r_rdata <= (r_pwrite || PSLVERR) ? '0 : PRDATA;
        r_err   <= PSLVERR;
      end else if (w_abort) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
    end
  end

  assign req_ready = (r_state == S_IDLE);
  assign PSEL      = (r_state == S_SETUP) || (r_state == S_ACCESS);
  assign PENABLE   = (r_state == S_ACCESS);
  assign rsp_valid = (r_state == S_RESP);
  assign PWRITE    = r_pwrite;
  assign PADDR     = r_paddr;
  assign PWDATA    = r_pwdata;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule

// File: tb/tb_ef_apb_master_bridge.sv
// Bench for ef_apb_master_bridge: timeline/scoreboard model checked every cycle,
// reactive APB responder with memory, directed scenarios plus randomized traffic.
module tb_ef_apb_master_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;
`ifdef EF_APBM_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic PCLK = 1'b0;
  logic PRESET;
  logic req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic rsp_valid, rsp_ready, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA, PRDATA;

  always #5 PCLK = ~PCLK;

  ef_apb_master_bridge #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          w;      // wait states the responder inserts
    logic        err;    // responder raises PSLVERR
    int          stall;  // RESP cycles before the agent accepts
  } plan_t;

  plan_t cur, fly;
  int total = 0, bad = 0;

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  // Responder: waits fly.w cycles in ACCESS, memory updated by error-free writes.
  int acc = 0;
  logic [31:0] smem [16];
  assign PREADY  = PSEL && PENABLE && (acc == fly.w);
  assign PRDATA  = smem[PADDR[5:2]];
  assign PSLVERR = PSEL && PENABLE && fly.err;

  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc <= acc + 1;
    else                            acc <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !PSLVERR) smem[PADDR[5:2]] <= PWDATA;
  end

  // Agent response side: hold off rsp_ready for fly.stall RESP cycles.
  int vc = 0;
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge PCLK); #1;
      if (rsp_valid) begin
        rsp_ready = (vc >= fly.stall);
        vc++;
      end else begin
        rsp_ready = 1'b0;
        vc = 0;
      end
    end
  end

  // Model: each transfer is a timeline relative to its request handshake cycle h:
  // SETUP at h+1, ACCESS h+2..h+2+ew, response from h+3+ew until accepted.
  bit act = 0, abrt = 0;
  int cyc = 0, h = 0, ew = 0, el = 0;
  bit e_ps, e_pe, e_rv;
  logic [31:0] mmem [16];
  logic [31:0] exp_rd, last_rd;
  logic exp_err, last_err;
  int hs_prev = 0, hs_last = 0, pen_cnt = 0, last_pen = 0, nrsp = 0;

  always @(negedge PCLK) begin
    cyc++;
    if (PRESET) begin
      act = 0;
    end else begin
      el   = cyc - h;
      e_ps = act && el >= 1 && el <= 2 + ew;
      e_pe = act && el >= 2 && el <= 2 + ew;
      e_rv = act && el >= 3 + ew;
      chk("req_ready", req_ready, !act);
      chk("psel", PSEL, e_ps);
      chk("penable", PENABLE, e_pe);
      chk("rsp_valid", rsp_valid, e_rv);
      if (e_ps) begin
        chk("paddr", PADDR, fly.addr);
        chk("pwrite", PWRITE, fly.wr);
        if (fly.wr) chk("pwdata", PWDATA, fly.data);
      end
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, exp_rd);
        chk("rsp_err", rsp_err, exp_err);
      end
      if (PENABLE) pen_cnt++;
      if (act && e_rv && rsp_valid && rsp_ready) begin
        act      = 0;
        last_rd  = rsp_rdata;
        last_err = rsp_err;
        last_pen = pen_cnt;
        nrsp++;
        if (fly.wr && !fly.err && !abrt) mmem[fly.addr[5:2]] = fly.data;
      end else if (!act && req_valid && req_ready) begin
        act     = 1;
        h       = cyc;
        fly     = cur;
        hs_prev = hs_last;
        hs_last = cyc;
        pen_cnt = 0;
        abrt    = TO_EN && (cur.w >= TO);
        ew      = abrt ? TO - 1 : cur.w;
        exp_err = cur.err || abrt;
        exp_rd  = (cur.wr || exp_err) ? 32'h0 : mmem[cur.addr[5:2]];
      end
    end
  end

  function automatic plan_t mk(input logic wr, input logic [31:0] a, input logic [31:0] d,
                               input int w, input logic e, input int st);
    plan_t p;
    p.wr = wr; p.addr = a; p.data = d; p.w = w; p.err = e; p.stall = st;
    return p;
  endfunction

  task automatic send(input plan_t p);
    bit ok;
    ok = 0;
    cur = p;
    req_write = p.wr; req_addr = p.addr; req_wdata = p.data; req_valid = 1'b1;
    for (int n = 0; n < 300; n++) begin
      @(negedge PCLK);
      if (req_ready) begin ok = 1; break; end
    end
    if (!ok) chk("req_handshake_timeout", 0, 1);
    @(posedge PCLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400; i++) begin
      @(posedge PCLK); #1;
      if (!act && !PSEL && !rsp_valid) return;
    end
    chk("done_timeout", 0, 1);
  endtask

  int n0, n1;
  plan_t rp;

  initial begin
    for (int i = 0; i < 16; i++) begin smem[i] = 32'h0; mmem[i] = 32'h0; end
    cur = mk(0, 0, 0, 0, 0, 0);
    fly = cur;
    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge PCLK); #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_psel", PSEL, 0);
    chk("rst_penable", PENABLE, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_paddr", PADDR, 0);
    chk("rst_pwdata", PWDATA, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    PRESET = 1'b0;

    // zero-wait write then read, back to back
    send(mk(1, 32'h10, 32'hA5, 0, 0, 0));
    send(mk(0, 32'h10, 32'h0, 0, 0, 0));
    wait_done();
    chk("t1_latency", hs_last - hs_prev, 4);
    chk("t1_rdata", last_rd, 32'hA5);
    chk("t1_err", last_err, 0);

    // three wait states
    send(mk(1, 32'h24, 32'hDEADBEEF, 3, 0, 0));
    wait_done();
    chk("t2_penable_cycles", last_pen, 4);

    // read with PSLVERR while responder returns 0x1234
    send(mk(1, 32'h30, 32'h1234, 0, 0, 0));
    send(mk(0, 32'h30, 32'h0, 0, 1, 0));
    wait_done();
    chk("t3_rdata", last_rd, 0);
    chk("t3_err", last_err, 1);

    // response back-pressure with a second request waiting
    send(mk(0, 32'h10, 32'h0, 0, 0, 5));
    send(mk(1, 32'h14, 32'h55, 0, 0, 0));
    wait_done();
    chk("t4_hs_spacing", hs_last - hs_prev, 9);

    // reset in the middle of ACCESS
    n0 = nrsp;
    send(mk(0, 32'h10, 32'h0, 20, 0, 0));
    repeat (3) @(posedge PCLK);
    #1;
    chk("t5_in_access", PENABLE, 1);
    PRESET = 1'b1;
    @(posedge PCLK); #1;
    chk("t5_psel", PSEL, 0);
    chk("t5_penable", PENABLE, 0);
    chk("t5_rsp_valid", rsp_valid, 0);
    chk("t5_req_ready", req_ready, 1);
    PRESET = 1'b0;
    repeat (6) @(posedge PCLK);
    #1;
    chk("t5_no_response", nrsp, n0);

`ifdef EF_APBM_TIMEOUT_EN
    send(mk(0, 32'h10, 32'h0, 30, 0, 0));
    wait_done();
    chk("t6_abort_err", last_err, 1);
    chk("t6_abort_rdata", last_rd, 0);
    chk("t6_abort_cycles", last_pen, 8);
    send(mk(0, 32'h10, 32'h0, 7, 0, 0));
    wait_done();
    chk("t6_late_err", last_err, 0);
    chk("t6_late_rdata", last_rd, 32'hA5);
    chk("t6_late_cycles", last_pen, 8);
`endif

    // randomized traffic
    n1 = nrsp;
    for (int k = 0; k < 80; k++) begin
      rp.wr    = 1'($urandom_range(0, 1));
      rp.addr  = $urandom();
      rp.addr[1:0] = 2'b00;
      rp.data  = $urandom();
      rp.w     = int'($urandom_range(0, TO_EN ? 10 : 4));
      rp.err   = ($urandom_range(0, 7) == 0);
      rp.stall = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(0, 3));
      send(rp);
    end
    wait_done();
    chk("rand_responses", nrsp - n1, 80);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
